rmac_operand_feeder: RTL and testbench

- Upstream stage of the rmac multiply-accumulate neuron.
- Collects S (weight, input) sign-magnitude operand pairs from a valid/ready stream into a local buffer, then replays them to the MAC on S consecutive cycles with en_s2/local_en asserted.
- Waits for the MAC's ReLU'd sum to settle, pulses sum_valid, and clears the MAC for the next dot product.

---
 rtl/rmac_pkg.sv | 19 +
 rtl/rmac_opbuf.sv | 25 ++
 rtl/rmac_operand_feeder.sv | 139 +++++++++++++
 tb/tb_rmac_operand_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmac_pkg.sv
// Shared types and defaults for the rmac operand feeder and its buffer.
package rmac_pkg;

  typedef logic [1:0] state_t;

  localparam state_t FILL   = 2'd0;
  localparam state_t STREAM = 2'd1;
  localparam state_t DRAIN  = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int unsigned S_DEF        = 8;
  localparam int unsigned N_DEF        = 32;
  localparam int unsigned INTBITS_DEF  = 12;
  localparam int unsigned FRACBITS_DEF = 20;

  // Sign-magnitude negative zero at the default word width.
  localparam logic [N_DEF-1:0] SM_NEG_ZERO = {1'b1, (N_DEF-1)'(0)};

endpackage

// File: rtl/rmac_opbuf.sv
// Operand pair register file: one synchronous write port, one asynchronous read port.
module rmac_opbuf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rmac_operand_feeder.sv
// Collects S operand pairs, replays them to the MAC back-to-back, then waits for
// the sum to settle, flags it and clears the MAC for the next dot product.
module rmac_operand_feeder
  import rmac_pkg::*;
#(
  parameter int unsigned S        = S_DEF,
  parameter int unsigned n        = N_DEF,
  parameter int unsigned intbits  = INTBITS_DEF,
  parameter int unsigned fracbits = FRACBITS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_w,
  input  logic [n-1:0] in_x,
  output logic [n-1:0] W,
  output logic [n-1:0] X,
  output logic         en_s2,
  output logic         local_en,
  output logic         mac_clr,
  output logic         sum_valid,
  output logic         busy
);

  localparam int unsigned PW = (S > 1) ? $clog2(S) : 1;
  localparam logic [PW-1:0] LAST = PW'(S - 1);
  localparam logic [n-1:0] NEG_ZERO = {1'b1, (n-1)'(0)};

  if (intbits + fracbits != n) begin : g_qfmt_check
    $error("rmac_operand_feeder: intbits + fracbits must equal n");
  end

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          drain_cnt;
  logic          post_rst;
  logic          accept_c;
  logic [n-1:0]  w_norm_c;
  logic [n-1:0]  x_norm_c;
  logic [2*n-1:0] rd_pair_c;

  logic in_ready_d;
  logic en_d;
  logic busy_d;
  logic sum_valid_d;
  logic mac_clr_d;

  assign accept_c = in_valid & in_ready;

  // Negative zero is folded to +0 on capture so the MAC never sees it.
  assign w_norm_c = (in_w == NEG_ZERO) ? '0 : in_w;
  assign x_norm_c = (in_x == NEG_ZERO) ? '0 : in_x;

  rmac_opbuf #(
    .DEPTH (S),
    .WIDTH (2*n),
    .AW    (PW)
  ) u_opbuf (
    .clk   (clk),
    .we    (accept_c),
    .waddr (wptr),
    .wdata ({w_norm_c, x_norm_c}),
    .raddr (rptr),
    .rdata (rd_pair_c)
  );

  assign W = (state == STREAM) ? rd_pair_c[2*n-1:n] : '0;
  assign X = (state == STREAM) ? rd_pair_c[n-1:0]   : '0;

  // State, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      wptr      <= '0;
      rptr      <= '0;
      drain_cnt <= 1'b0;
      post_rst  <= 1'b1;
      in_ready  <= 1'b1;
      en_s2     <= 1'b0;
      local_en  <= 1'b0;
      busy      <= 1'b0;
      sum_valid <= 1'b0;
      mac_clr   <= 1'b1;
    end else begin
      state     <= state_nx;
      post_rst  <= 1'b0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (accept_c) begin
        wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
      end
      if (state == STREAM) begin
        rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      end
      in_ready  <= in_ready_d;
      en_s2     <= en_d;
      local_en  <= en_d;
      busy      <= busy_d;
      sum_valid <= sum_valid_d;
      mac_clr   <= mac_clr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:    if (accept_c && (wptr == LAST)) state_nx = STREAM;
      STREAM:  if (rptr == LAST) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = DONE;
      DONE:    state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with it.
  always_comb begin
    in_ready_d  = 1'b0;
    en_d        = 1'b0;
    busy_d      = 1'b1;
    sum_valid_d = 1'b0;
    mac_clr_d   = post_rst;
    unique case (state_nx)
      FILL: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      STREAM:  en_d = 1'b1;
      DONE: begin
        sum_valid_d = 1'b1;
        mac_clr_d   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rmac_operand_feeder.sv
// Randomized bench for rmac_operand_feeder against a frame-timeline reference model
// plus a behavioural sign-magnitude MAC fed from the DUT outputs.
module tb_rmac_operand_feeder;

  localparam int unsigned S  = 8;
  localparam int unsigned N  = 32;
  localparam int unsigned FB = 20;

  typedef struct packed {
    logic [N-1:0] w;
    logic [N-1:0] x;
  } pair_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_w;
  logic [N-1:0] in_x;
  logic [N-1:0] W;
  logic [N-1:0] X;
  logic         en_s2;
  logic         local_en;
  logic         mac_clr;
  logic         sum_valid;
  logic         busy;

  always #5 clk = ~clk;

  rmac_operand_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_x      (in_x),
    .W         (W),
    .X         (X),
    .en_s2     (en_s2),
    .local_en  (local_en),
    .mac_clr   (mac_clr),
    .sum_valid (sum_valid),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  pair_t  tx_q[$];
  pair_t  frame_q[$];
  int     phase_t  = -1;
  int     clr_left = 0;
  bit     armed    = 1'b0;
  bit     stall    = 1'b0;
  int     stall_k  = 0;
  int     cyc      = 0;
  int     en_cnt   = 0;
  int     sv_cnt   = 0;
  int     sv_exp   = 0;
  int     sv_last  = -1;
  int     sv_prev  = -1;
  longint mac_acc  = 0;
  logic [N-1:0] last_sum = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] norm(input logic [N-1:0] v);
    logic [N-1:0] nz;
    nz = {1'b1, {(N-1){1'b0}}};
    return (v == nz) ? '0 : v;
  endfunction

  // Q12.20 sign-magnitude product, truncated toward zero.
  function automatic longint prod(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = (longint'(a[N-2:0]) * longint'(b[N-2:0])) >>> FB;
    return (a[N-1] ^ b[N-1]) ? -p : p;
  endfunction

  function automatic logic [N-1:0] relu(input longint s);
    return (s < 0) ? '0 : N'(s);
  endfunction

  function automatic logic [N-1:0] model_sum();
    longint s = 0;
    foreach (frame_q[i]) s += prod(frame_q[i].w, frame_q[i].x);
    return relu(s);
  endfunction

  function automatic logic [N-1:0] rnd_word();
    logic [N-1:0] v;
    v = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0040_0000))};
    if ($urandom_range(0, 15) == 0) v = {1'b1, {(N-1){1'b0}}};
    return v;
  endfunction

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic run_cycle(input logic rst);
    logic  v;
    logic  exp_en;
    pair_t p;
    @(negedge clk);
    if (armed) begin
      exp_en = (phase_t >= 0) && (phase_t < S);
      check_eq("in_ready", in_ready, phase_t < 0);
      check_eq("busy", busy, phase_t >= 0);
      check_eq("en_s2", en_s2, exp_en);
      check_eq("local_en", local_en, exp_en);
      check_eq("W", W, exp_en ? frame_q[phase_t].w : '0);
      check_eq("X", X, exp_en ? frame_q[phase_t].x : '0);
      check_eq("sum_valid", sum_valid, phase_t == S + 2);
      check_eq("mac_clr", mac_clr, (phase_t == S + 2) || (clr_left > 0));
      if (phase_t == S + 2) check_eq("sum", relu(mac_acc), model_sum());
      if (en_s2) en_cnt++;
      if (sum_valid) begin
        sv_cnt++;
        sv_prev  = sv_last;
        sv_last  = cyc;
        last_sum = relu(mac_acc);
      end
      if (mac_clr) mac_acc = 0;
      else if (en_s2) mac_acc += prod(W, X);
    end
    v = (tx_q.size() > 0) && (!stall || (stall_k % 2 == 0));
    p = (tx_q.size() > 0) ? tx_q[0] : pair_t'({rnd_word(), rnd_word()});
    reset    = rst;
    in_valid = v;
    in_w     = p.w;
    in_x     = p.x;
    if (!rst) begin
      phase_t  = -1;
      frame_q.delete();
      clr_left = 2;
    end else begin
      if (clr_left > 0) clr_left--;
      if (phase_t < 0) begin
        if (v) begin
          frame_q.push_back('{w: norm(p.w), x: norm(p.x)});
          void'(tx_q.pop_front());
          if (frame_q.size() == S) phase_t = 0;
        end
      end else if (phase_t == S + 2) begin
        phase_t = -1;
        frame_q.delete();
        sv_exp++;
      end else begin
        phase_t++;
      end
    end
    armed = 1'b1;
    stall_k++;
    cyc++;
  endtask

  task automatic pump(input bit st, output int ncyc);
    stall   = st;
    stall_k = 0;
    ncyc    = 0;
    for (int i = 0; i < 400 && tx_q.size() > 0; i++) begin
      run_cycle(1'b1);
      ncyc++;
    end
    check_eq("pump_drained", tx_q.size(), 0);
    stall = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && phase_t >= 0; i++) run_cycle(1'b1);
    check_eq("frame_completes", phase_t < 0, 1'b1);
    run_cycle(1'b1);
  endtask

  task automatic push_n(input int cnt, input logic [N-1:0] w, input logic [N-1:0] x);
    for (int i = 0; i < cnt; i++) tx_q.push_back('{w: w, x: x});
  endtask

  task automatic push_rand(input int cnt);
    for (int i = 0; i < cnt; i++) tx_q.push_back('{w: rnd_word(), x: rnd_word()});
  endtask

  initial begin
    int nc;
    int sv_before;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_w     = '0;
    in_x     = '0;
    run_cycle(1'b0);
    run_cycle(1'b0);

    // 1.0 x 2.0 eight times
    en_cnt = 0;
    push_n(8, 32'h0010_0000, 32'h0020_0000);
    pump(1'b0, nc);
    wait_idle();
    check_eq("t1_en_cycles", en_cnt, 8);
    check_eq("t1_sum", last_sum, 32'h0100_0000);

    // mixed signs
    push_n(4, 32'h0010_0000, 32'h0030_0000);
    push_n(4, 32'h0010_0000, 32'h8010_0000);
    pump(1'b0, nc);
    wait_idle();
    check_eq("t2_sum", last_sum, 32'h0080_0000);

    // all products negative: ReLU clamps to zero
    push_n(8, 32'h0010_0000, 32'h8010_0000);
    pump(1'b0, nc);
    wait_idle();
    check_eq("t2_relu", last_sum, 32'h0000_0000);

    // alternating in_valid
    en_cnt = 0;
    push_rand(8);
    pump(1'b1, nc);
    check_eq("stall_fill_cycles", nc, 15);
    check_eq("stall_no_en_in_fill", en_cnt, 0);
    wait_idle();

    // negative zero on both operands
    push_rand(2);
    tx_q.push_back('{w: 32'h8000_0000, x: 32'h0010_0000});
    push_rand(2);
    tx_q.push_back('{w: 32'h0020_0000, x: 32'h8000_0000});
    push_rand(2);
    pump(1'b0, nc);
    wait_idle();

    // reset during the 4th stream cycle
    sv_before = sv_cnt;
    push_rand(8);
    pump(1'b0, nc);
    for (int i = 0; i < 10 && phase_t < 3; i++) run_cycle(1'b1);
    check_eq("abort_at_slot4", phase_t, 3);
    run_cycle(1'b0);
    for (int i = 0; i < 14; i++) run_cycle(1'b1);
    check_eq("abort_no_sv", sv_cnt, sv_before);
    push_n(8, 32'h0010_0000, 32'h0020_0000);
    pump(1'b0, nc);
    wait_idle();
    check_eq("post_abort_sum", last_sum, 32'h0100_0000);

    // back-to-back frames with in_valid held high
    push_rand(16);
    pump(1'b0, nc);
    wait_idle();
    check_eq("b2b_gap", sv_last - sv_prev, 2 * S + 3);

    // random frames with random stalls
    for (int f = 0; f < 4; f++) begin
      push_rand(S);
      pump(1'($urandom_range(0, 1)), nc);
      wait_idle();
    end

    check_eq("sv_count", sv_cnt, sv_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
